// File: rtl/mem_stage.sv
// mem_stage: MIPS-style data-memory pipeline stage.
// It drives a ready/request data-memory port and aligns bytes and halfwords onto
// little-endian lanes. Loads are sign- or zero-extended. A slow memory stalls the
// upstream pipeline. An access is aborted after TIMEOUT_CYCLES wait cycles.
// Misaligned accesses become bubbles and pulse mem_fault.
module mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] EX_MEM_alu_result,
  input  logic [31:0] EX_MEM_B_value,
  input  logic [4:0]  EX_MEM_dst_reg,
  input  logic [5:0]  EX_MEM_opcode,
  input  logic        EX_MEM_mem_read,
  input  logic        EX_MEM_mem_write,
  input  logic        EX_MEM_wb_reg_write,
  input  logic        EX_MEM_wb_mem_to_reg,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic        mem_fault,
  output logic [31:0] mem_fwd_val,
  output logic [31:0] wb_fwd_val,
  output logic [31:0] MEM_WB_alu_result,
  output logic [31:0] MEM_WB_mem_data,
  output logic [4:0]  MEM_WB_dst_reg,
  output logic        MEM_WB_wb_reg_write,
  output logic        MEM_WB_wb_mem_to_reg
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

  // Value of the wait counter in the last WAIT cycle before an abort.
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  size_t       size;
  logic        ld_signed, access, is_write, misaligned;
  logic        req_c, stall_c, fault_c, complete_c;
  logic [3:0]  store_be;
  logic [31:0] store_wdata, load_data;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] alu_d, data_d;
  logic [4:0]  dst_d;
  logic        reg_write_d, mem_to_reg_d;

  // A read-and-write request is treated as a read.
  assign access   = EX_MEM_mem_read | EX_MEM_mem_write;
  assign is_write = EX_MEM_mem_write & ~EX_MEM_mem_read;

  // Decode the access size and signedness from the opcode. Unknown opcodes are word accesses.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    size      = SZ_WORD;
    ld_signed = 1'b0;
    case (EX_MEM_opcode)
      6'h20:        begin size = SZ_BYTE; ld_signed = 1'b1; end
      6'h21:        begin size = SZ_HALF; ld_signed = 1'b1; end
      6'h24, 6'h28: size = SZ_BYTE;
      6'h25, 6'h29: size = SZ_HALF;
      default:      size = SZ_WORD;
    endcase
  end

  assign misaligned = access &
                      (((size == SZ_HALF) && EX_MEM_alu_result[0]) ||
                       ((size == SZ_WORD) && (EX_MEM_alu_result[1:0] != 2'b00)));

  // Place store data on its byte lanes. Loads always read the whole word.
  always_comb begin
    store_be    = 4'b1111;
    store_wdata = EX_MEM_B_value;
    if (is_write) begin
      case (size)
        SZ_BYTE: begin
          store_be    = 4'b0001 << EX_MEM_alu_result[1:0];
          store_wdata = {4{EX_MEM_B_value[7:0]}};
        end
        SZ_HALF: begin
          store_be    = EX_MEM_alu_result[1] ? 4'b1100 : 4'b0011;
          store_wdata = {2{EX_MEM_B_value[15:0]}};
        end
        default: begin
          store_be    = 4'b1111;
          store_wdata = EX_MEM_B_value;
        end
      endcase
    end
  end

  // Select the addressed lane of the read word and extend it to 32 bits.
  always_comb begin
    lane_byte = dmem_rdata[{EX_MEM_alu_result[1:0], 3'b000} +: 8];
    lane_half = EX_MEM_alu_result[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (size)
      SZ_BYTE: load_data = {{24{ld_signed & lane_byte[7]}}, lane_byte};
      SZ_HALF: load_data = {{16{ld_signed & lane_half[15]}}, lane_half};
      default: load_data = dmem_rdata;
    endcase
  end

  // Next-state logic and handshake outputs for the IDLE/WAIT access FSM.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    req_c      = 1'b0;
    stall_c    = 1'b0;
    fault_c    = 1'b0;
    complete_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (misaligned) begin
          fault_c = 1'b1;
        end else if (access) begin
          req_c = 1'b1;
          if (dmem_ready) begin
            complete_c = 1'b1;
          end else begin
            stall_c = 1'b1;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (dmem_ready) begin
          // If ready and the timeout fall in the same cycle, the access completes normally.
          req_c      = 1'b1;
          complete_c = 1'b1;
          wait_cnt_d = '0;
          state_d    = S_IDLE;
        end else if (wait_cnt_q == LAST_WAIT) begin
          fault_c    = 1'b1;
          wait_cnt_d = '0;
          state_d    = S_IDLE;
        end else begin
          req_c      = 1'b1;
          stall_c    = 1'b1;
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: these outputs are combinational, so they are gated with rst. This drops them
  // the moment reset asserts, even while the EX_MEM inputs still request an access.
  assign dmem_req    = rst & req_c;
  assign mem_stall   = rst & stall_c;
  assign mem_fault   = rst & fault_c;
  assign dmem_we     = is_write;
  assign dmem_be     = store_be;
  assign dmem_addr   = {EX_MEM_alu_result[31:2], 2'b00};
  assign dmem_wdata  = store_wdata;
  assign mem_fwd_val = EX_MEM_alu_result;

  // Next value of MEM_WB. A stall inserts a bubble that keeps its data fields.
  // A fault inserts a bubble that loads its fields as usual.
  always_comb begin
    alu_d        = MEM_WB_alu_result;
    data_d       = MEM_WB_mem_data;
    dst_d        = MEM_WB_dst_reg;
    mem_to_reg_d = MEM_WB_wb_mem_to_reg;
    reg_write_d  = 1'b0;
    if (!stall_c) begin
      alu_d        = EX_MEM_alu_result;
      data_d       = (complete_c && EX_MEM_mem_read) ? load_data : 32'h0;
      dst_d        = EX_MEM_dst_reg;
      mem_to_reg_d = EX_MEM_wb_mem_to_reg;
      reg_write_d  = EX_MEM_wb_reg_write & ~fault_c;
    end
  end

  // FSM state and wait counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // MEM_WB pipeline register. It clears on reset and loads on every clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      MEM_WB_alu_result    <= '0;
      MEM_WB_mem_data      <= '0;
      MEM_WB_dst_reg       <= '0;
      MEM_WB_wb_reg_write  <= 1'b0;
      MEM_WB_wb_mem_to_reg <= 1'b0;
    end else begin
      MEM_WB_alu_result    <= alu_d;
      MEM_WB_mem_data      <= data_d;
      MEM_WB_dst_reg       <= dst_d;
      MEM_WB_wb_reg_write  <= reg_write_d;
      MEM_WB_wb_mem_to_reg <= mem_to_reg_d;
    end
  end

  assign wb_fwd_val = MEM_WB_wb_mem_to_reg ? MEM_WB_mem_data : MEM_WB_alu_result;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: self-checking bench for mem_stage.
// A table of single-cycle accesses is followed by hand-written wait, timeout and reset sequences.
// Expected MEM_WB contents are queued when stimulus is driven and compared after the clock edge.
module tb_mem_stage;
  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] EX_MEM_alu_result, EX_MEM_B_value;
  logic [4:0]  EX_MEM_dst_reg;
  logic [5:0]  EX_MEM_opcode;
  logic        EX_MEM_mem_read, EX_MEM_mem_write, EX_MEM_wb_reg_write, EX_MEM_wb_mem_to_reg;
  logic        dmem_req, dmem_we, dmem_ready, mem_stall, mem_fault;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, mem_fwd_val, wb_fwd_val;
  logic [31:0] MEM_WB_alu_result, MEM_WB_mem_data;
  logic [4:0]  MEM_WB_dst_reg;
  logic        MEM_WB_wb_reg_write, MEM_WB_wb_mem_to_reg;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .EX_MEM_alu_result(EX_MEM_alu_result), .EX_MEM_B_value(EX_MEM_B_value),
    .EX_MEM_dst_reg(EX_MEM_dst_reg), .EX_MEM_opcode(EX_MEM_opcode),
    .EX_MEM_mem_read(EX_MEM_mem_read), .EX_MEM_mem_write(EX_MEM_mem_write),
    .EX_MEM_wb_reg_write(EX_MEM_wb_reg_write), .EX_MEM_wb_mem_to_reg(EX_MEM_wb_mem_to_reg),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall), .mem_fault(mem_fault),
    .mem_fwd_val(mem_fwd_val), .wb_fwd_val(wb_fwd_val),
    .MEM_WB_alu_result(MEM_WB_alu_result), .MEM_WB_mem_data(MEM_WB_mem_data),
    .MEM_WB_dst_reg(MEM_WB_dst_reg), .MEM_WB_wb_reg_write(MEM_WB_wb_reg_write),
    .MEM_WB_wb_mem_to_reg(MEM_WB_wb_mem_to_reg)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] data;
    logic [4:0]  dst;
    logic        regw;
    logic        m2r;
    logic        chk_data;
  } wb_exp_t;

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] b;
    logic        rd;
    logic        wr;
    logic        regw;
    logic        m2r;
    logic [31:0] rdata;
    logic        e_req;
    logic        e_we;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic        e_fault;
    logic [31:0] e_data;
  } vec_t;

  wb_exp_t sb_q[$];
  wb_exp_t m = '{default: '0};
  vec_t    vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_instr(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] b,
                           input logic rd, input logic wr, input logic [4:0] dst,
                           input logic regw, input logic m2r);
    EX_MEM_opcode        = op;
    EX_MEM_alu_result    = addr;
    EX_MEM_B_value       = b;
    EX_MEM_mem_read      = rd;
    EX_MEM_mem_write     = wr;
    EX_MEM_dst_reg       = dst;
    EX_MEM_wb_reg_write  = regw;
    EX_MEM_wb_mem_to_reg = m2r;
  endtask

  // Model of the next MEM_WB contents, queued for comparison after the edge.
  task automatic predict(input logic stall, input logic fault, input logic load_done,
                         input logic [31:0] data);
    if (stall) begin
      m.regw = 1'b0;
    end else begin
      m.alu      = EX_MEM_alu_result;
      m.dst      = EX_MEM_dst_reg;
      m.m2r      = EX_MEM_wb_mem_to_reg;
      m.regw     = EX_MEM_wb_reg_write & ~fault;
      m.data     = load_done ? data : 32'h0;
      m.chk_data = ~fault;
    end
    sb_q.push_back(m);
  endtask

  task automatic edge_and_check(input string tag);
    wb_exp_t e;
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s.scoreboard: got empty queue expected an entry", tag);
      return;
    end
    e = sb_q.pop_front();
    check($sformatf("%s.wb_alu", tag), MEM_WB_alu_result, e.alu);
    check($sformatf("%s.wb_regw", tag), 32'(MEM_WB_wb_reg_write), 32'(e.regw));
    check($sformatf("%s.wb_dst", tag), 32'(MEM_WB_dst_reg), 32'(e.dst));
    check($sformatf("%s.wb_m2r", tag), 32'(MEM_WB_wb_mem_to_reg), 32'(e.m2r));
    if (e.chk_data) begin
      check($sformatf("%s.wb_data", tag), MEM_WB_mem_data, e.data);
      check($sformatf("%s.wb_fwd", tag), wb_fwd_val, e.m2r ? e.data : e.alu);
    end
  endtask

  task automatic check_bus(input string tag, input logic e_req, input logic e_stall,
                           input logic e_fault, input logic e_we, input logic [3:0] e_be,
                           input logic [31:0] e_wdata, input logic chk_wdata);
    logic [31:0] word_addr;
    @(negedge clk);
    word_addr = {EX_MEM_alu_result[31:2], 2'b00};
    check($sformatf("%s.req", tag), 32'(dmem_req), 32'(e_req));
    check($sformatf("%s.stall", tag), 32'(mem_stall), 32'(e_stall));
    check($sformatf("%s.fault", tag), 32'(mem_fault), 32'(e_fault));
    check($sformatf("%s.mem_fwd", tag), mem_fwd_val, EX_MEM_alu_result);
    if (e_req) begin
      check($sformatf("%s.we", tag), 32'(dmem_we), 32'(e_we));
      check($sformatf("%s.be", tag), 32'(dmem_be), 32'(e_be));
      check($sformatf("%s.addr", tag), dmem_addr, word_addr);
      if (chk_wdata) check($sformatf("%s.wdata", tag), dmem_wdata, e_wdata);
    end
  endtask

  initial begin
    int stall_cnt;

    //          name        op     addr          b             rd wr rw m2r rdata        req we be       wdata         flt data
    vecs[0]  = '{"lw",       6'h23, 32'h100,      32'h0,        1, 0, 1, 1, 32'h11223344, 1, 0, 4'b1111, 32'h0,        0, 32'h11223344};
    vecs[1]  = '{"lb",       6'h20, 32'h103,      32'h0,        1, 0, 1, 1, 32'h80FFFFFF, 1, 0, 4'b1111, 32'h0,        0, 32'hFFFFFF80};
    vecs[2]  = '{"lbu",      6'h24, 32'h103,      32'h0,        1, 0, 1, 1, 32'h80FFFFFF, 1, 0, 4'b1111, 32'h0,        0, 32'h00000080};
    vecs[3]  = '{"lb0",      6'h20, 32'h010,      32'h0,        1, 0, 1, 1, 32'h1234567F, 1, 0, 4'b1111, 32'h0,        0, 32'h0000007F};
    vecs[4]  = '{"lh",       6'h21, 32'h102,      32'h0,        1, 0, 1, 1, 32'h80011234, 1, 0, 4'b1111, 32'h0,        0, 32'hFFFF8001};
    vecs[5]  = '{"lhu",      6'h25, 32'h100,      32'h0,        1, 0, 1, 1, 32'h8001F234, 1, 0, 4'b1111, 32'h0,        0, 32'h0000F234};
    vecs[6]  = '{"sb",       6'h28, 32'h102,      32'h000000AB, 0, 1, 0, 0, 32'h0,        1, 1, 4'b0100, 32'hABABABAB, 0, 32'h0};
    vecs[7]  = '{"sb0",      6'h28, 32'h010,      32'h1234561C, 0, 1, 0, 0, 32'h0,        1, 1, 4'b0001, 32'h1C1C1C1C, 0, 32'h0};
    vecs[8]  = '{"sh",       6'h29, 32'h102,      32'h1234CDEF, 0, 1, 0, 0, 32'h0,        1, 1, 4'b1100, 32'hCDEFCDEF, 0, 32'h0};
    vecs[9]  = '{"sw",       6'h2B, 32'h200,      32'hDEADBEEF, 0, 1, 0, 0, 32'h0,        1, 1, 4'b1111, 32'hDEADBEEF, 0, 32'h0};
    vecs[10] = '{"lh_mis",   6'h21, 32'h101,      32'h0,        1, 0, 1, 1, 32'h55555555, 0, 0, 4'b1111, 32'h0,        1, 32'h0};
    vecs[11] = '{"lw_mis",   6'h23, 32'h102,      32'h0,        1, 0, 1, 1, 32'h55555555, 0, 0, 4'b1111, 32'h0,        1, 32'h0};
    vecs[12] = '{"sw_mis",   6'h2B, 32'h201,      32'h12345678, 0, 1, 1, 0, 32'h0,        0, 1, 4'b1111, 32'h0,        1, 32'h0};
    vecs[13] = '{"alu_only", 6'h00, 32'hCAFE0000, 32'h0,        0, 0, 1, 0, 32'h77777777, 0, 0, 4'b1111, 32'h0,        0, 32'h0};
    vecs[14] = '{"rd_wr",    6'h23, 32'h104,      32'hFFFFFFFF, 1, 1, 1, 1, 32'h13572468, 1, 0, 4'b1111, 32'h0,        0, 32'h13572468};
    vecs[15] = '{"other_op", 6'h3F, 32'h108,      32'h0,        1, 0, 1, 0, 32'h0BADF00D, 1, 0, 4'b1111, 32'h0,        0, 32'h0BADF00D};

    // Reset state: an aligned request must not reach the memory while rst is low.
    rst = 1'b0;
    dmem_ready = 1'b0;
    dmem_rdata = 32'h0;
    set_instr(6'h23, 32'h100, 32'h0, 1, 0, 5'd3, 1, 1);
    check_bus("rst_lw", 0, 0, 0, 0, 4'b1111, 32'h0, 0);
    set_instr(6'h21, 32'h101, 32'h0, 1, 0, 5'd3, 1, 1);
    check_bus("rst_mis", 0, 0, 0, 0, 4'b1111, 32'h0, 0);
    @(posedge clk);
    #1;
    check("rst.wb_alu", MEM_WB_alu_result, 32'h0);
    check("rst.wb_data", MEM_WB_mem_data, 32'h0);
    check("rst.wb_dst", 32'(MEM_WB_dst_reg), 32'h0);
    check("rst.wb_regw", 32'(MEM_WB_wb_reg_write), 32'h0);
    check("rst.wb_m2r", 32'(MEM_WB_wb_mem_to_reg), 32'h0);
    rst = 1'b1;

    // Single-cycle accesses: zero wait states, or misaligned.
    for (int i = 0; i < 16; i++) begin
      set_instr(vecs[i].op, vecs[i].addr, vecs[i].b, vecs[i].rd, vecs[i].wr, 5'(i + 1),
                vecs[i].regw, vecs[i].m2r);
      dmem_ready = 1'b1;
      dmem_rdata = vecs[i].rdata;
      check_bus(vecs[i].name, vecs[i].e_req, 0, vecs[i].e_fault, vecs[i].e_we, vecs[i].e_be,
                vecs[i].e_wdata, vecs[i].e_we);
      predict(0, vecs[i].e_fault, vecs[i].rd & ~vecs[i].e_fault, vecs[i].e_data);
      edge_and_check(vecs[i].name);
    end

    // SW with ready delayed 3 cycles: 3 stall cycles, address held, 3 bubbles.
    set_instr(6'h2B, 32'h200, 32'h55667788, 0, 1, 5'd20, 0, 0);
    dmem_rdata = 32'h0;
    stall_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      dmem_ready = (c == 3);
      check_bus($sformatf("sw_wait%0d", c), 1, c < 3, 0, 1, 4'b1111, 32'h55667788, 1);
      if (mem_stall) stall_cnt++;
      predict(c < 3, 0, 0, 32'h0);
      edge_and_check($sformatf("sw_wait%0d", c));
    end
    check("sw_wait.stall_cycles", 32'(stall_cnt), 32'd3);

    // LW with one wait state: data lands at the completing edge.
    set_instr(6'h23, 32'h300, 32'h0, 1, 0, 5'd7, 1, 1);
    dmem_rdata = 32'hA5A50001;
    for (int c = 0; c < 2; c++) begin
      dmem_ready = (c == 1);
      check_bus($sformatf("lw_wait%0d", c), 1, c < 1, 0, 0, 4'b1111, 32'h0, 0);
      predict(c < 1, 0, c == 1, 32'hA5A50001);
      edge_and_check($sformatf("lw_wait%0d", c));
    end

    // Timeout: ready never comes, so the access aborts on the 4th WAIT cycle.
    set_instr(6'h23, 32'h400, 32'h0, 1, 0, 5'd9, 1, 1);
    dmem_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check_bus($sformatf("tmo%0d", c), c < 4, c < 4, c == 4, 0, 4'b1111, 32'h0, 0);
      predict(c < 4, c == 4, 0, 32'h0);
      edge_and_check($sformatf("tmo%0d", c));
    end

    // Ready arrives in the cycle the timeout would fire: ready wins.
    set_instr(6'h23, 32'h404, 32'h0, 1, 0, 5'd10, 1, 1);
    dmem_rdata = 32'hCAFEF00D;
    for (int c = 0; c < 5; c++) begin
      dmem_ready = (c == 4);
      check_bus($sformatf("tmo_rdy%0d", c), 1, c < 4, 0, 0, 4'b1111, 32'h0, 0);
      predict(c < 4, 0, c == 4, 32'hCAFEF00D);
      edge_and_check($sformatf("tmo_rdy%0d", c));
    end

    // Reset mid-WAIT: the request drops without a clock edge and MEM_WB clears.
    set_instr(6'h23, 32'h500, 32'h0, 1, 0, 5'd11, 1, 1);
    dmem_ready = 1'b0;
    check_bus("rst_wait0", 1, 1, 0, 0, 4'b1111, 32'h0, 0);
    predict(1, 0, 0, 32'h0);
    edge_and_check("rst_wait0");
    #2;
    rst = 1'b0;
    #1;
    check("rst_wait.req", 32'(dmem_req), 32'h0);
    check("rst_wait.stall", 32'(mem_stall), 32'h0);
    check("rst_wait.fault", 32'(mem_fault), 32'h0);
    check("rst_wait.wb_regw", 32'(MEM_WB_wb_reg_write), 32'h0);
    check("rst_wait.wb_alu", MEM_WB_alu_result, 32'h0);
    m = '{default: '0};
    dmem_ready = 1'b1;
    dmem_rdata = 32'h600DF00D;
    rst = 1'b1;
    // The first access after reset starts from IDLE and completes with no wait states.
    check_bus("post_rst", 1, 0, 0, 0, 4'b1111, 32'h0, 0);
    predict(0, 0, 1, 32'h600DF00D);
    edge_and_check("post_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 255, max WAIT cycles before a data-memory access is aborted (range 1..255).
REQ-002 SHALL use one clock; reset is asynchronous and active-low.
REQ-003 SHALL have ports (name, direction, width, meaning):
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- EX_MEM_alu_result  in  32  byte address or ALU result
- EX_MEM_B_value  in  32  store data
- EX_MEM_dst_reg  in  5  destination register
- EX_MEM_opcode  in  6  MIPS opcode
- EX_MEM_mem_read  in  1  load request
- EX_MEM_mem_write  in  1  store request
- EX_MEM_wb_reg_write  in  1  writeback enable
- EX_MEM_wb_mem_to_reg  in  1  writeback select, 1 = memory data
- dmem_req  out  1  data-memory request
- dmem_we  out  1  1 = write
- dmem_be  out  4  byte enables
- dmem_addr  out  32  word address {addr[31:2],2'b00}
- dmem_wdata  out  32  lane-aligned store data
- dmem_ready  in  1  access complete this cycle
- dmem_rdata  in  32  read word, valid while dmem_ready=1
- mem_stall  out  1  freeze IF/ID/EX and EX_MEM registers
- mem_fault  out  1  one-cycle pulse on misalign or timeout
- mem_fwd_val  out  32  equals EX_MEM_alu_result, combinational
- wb_fwd_val  out  32  MEM_WB_mem_to_reg ? MEM_WB_mem_data : MEM_WB_alu_result
- MEM_WB_alu_result  out  32  registered
- MEM_WB_mem_data  out  32  registered, extended load data
- MEM_WB_dst_reg  out  5  registered
- MEM_WB_wb_reg_write  out  1  registered
- MEM_WB_wb_mem_to_reg  out  1  registered

Function
REQ-004 SHALL define access = mem_read | mem_write; mem_read and mem_write both high SHALL be treated as a read only.
REQ-005 SHALL decode loads LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25 and stores SB 0x28, SH 0x29, SW 0x2B; any other opcode with access asserted SHALL be treated as a word access.
REQ-006 SHALL use little-endian byte lanes: lane = addr[1:0]; halfword lane = addr[1].
REQ-007 Store data: SB SHALL replicate the byte into all 4 lanes with be = 1<<addr[1:0]; SH SHALL replicate the halfword with be = 0011 or 1100; SW SHALL use be = 1111. Loads SHALL drive be = 1111.
REQ-008 Loads: LB/LH SHALL sign-extend and LBU/LHU SHALL zero-extend the selected lane of dmem_rdata; LW SHALL pass the word through.
REQ-009 Misaligned access (halfword with addr[0]=1, word with addr[1:0]!=0) SHALL NOT assert dmem_req; mem_fault SHALL pulse for 1 cycle; mem_stall SHALL be 0; a bubble SHALL be written into MEM_WB.
REQ-010 FSM states are IDLE and WAIT.
REQ-011 IDLE: on an aligned access, dmem_req SHALL be 1 combinationally in the same cycle. If dmem_ready=1 the access completes with zero wait states and the state stays IDLE. Otherwise mem_stall=1 and the next state is WAIT.
REQ-012 WAIT: dmem_req, dmem_we, dmem_addr, dmem_be and dmem_wdata SHALL be held stable. The upstream stages hold the EX_MEM inputs frozen while mem_stall=1.
REQ-013 WAIT: an 8-bit wait counter SHALL increment each cycle with dmem_ready=0. When dmem_ready=1, the access completes, mem_stall=0, the counter clears and the next state is IDLE.
REQ-014 Timeout: when the counter reaches TIMEOUT_CYCLES with dmem_ready=0, the access SHALL abort. In that cycle: dmem_req=0, mem_fault pulses, mem_stall=0, a bubble is written into MEM_WB, and the next state is IDLE.
REQ-015 dmem_ready and the timeout in the same cycle: ready SHALL win and the access completes normally.
REQ-016 MEM_WB SHALL load each cycle in which mem_stall=0. The fields are alu_result, extended load data (0 for non-loads), dst_reg, wb_reg_write and wb_mem_to_reg.
REQ-017 In cycles with mem_stall=1, MEM_WB SHALL load a bubble: wb_reg_write=0, other fields unchanged.
REQ-018 A bubble SHALL force wb_reg_write=0; its other fields SHALL be loaded as normal.
REQ-019 Load-to-use latency: load data SHALL appear on MEM_WB_mem_data at the clock edge that completes the access.

Reset
REQ-020 While rst=0: state=IDLE, counter=0, all MEM_WB outputs 0, dmem_req=0, mem_stall=0, mem_fault=0, asynchronously.
REQ-021 Reset asserted during WAIT SHALL drop dmem_req immediately and abandon the access with no MEM_WB write.
REQ-022 After rst deasserts, the first aligned access SHALL start in IDLE.

Verification
REQ-023 LW addr 0x100, dmem_ready=1 same cycle, rdata 0x11223344 -> no stall; next edge MEM_WB_mem_data=0x11223344, MEM_WB_wb_reg_write=1.
REQ-024 LB addr 0x103, rdata 0x80FFFFFF -> MEM_WB_mem_data=0xFFFFFF80. LBU at the same address -> 0x00000080.
REQ-025 SB addr 0x102, B=0x000000AB -> dmem_be=0100, dmem_wdata=0xABABABAB, dmem_we=1.
REQ-026 SW addr 0x200, dmem_ready delayed 3 cycles -> mem_stall high exactly 3 cycles, address stable, 3 bubbles in MEM_WB, then the write completes.
REQ-027 LH addr 0x101 -> no dmem_req, mem_fault 1-cycle pulse, MEM_WB_wb_reg_write=0.
REQ-028 TIMEOUT_CYCLES=4, dmem_ready never asserts -> abort on the 4th WAIT cycle with mem_fault pulse and bubble. Reset pulled low mid-WAIT -> dmem_req drops without waiting for a clock edge.
